// File: rtl/darkriscv_wb_dbridge.sv
// darkriscv data port to Wishbone-classic bridge: one registered request at a
// time, byte-lane select/replication, core stall while busy, read-data
// alignment, bus-error and timeout reporting.

// Per-lane select bit and write byte for one Wishbone byte lane.
module darkriscv_wb_dbridge_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] off,
  input  logic [2:0] len,
  input  logic [7:0] b_byte,
  input  logic [7:0] b_half,
  input  logic [7:0] b_word,
  output logic       sel,
  output logic [7:0] wbyte
);
  localparam logic [1:0] ID = 2'(LANE);

  // Only meaningful for legal (aligned, one-hot) requests.
  always_comb begin
    sel   = 1'b1;
    wbyte = b_word;
    if (len[0]) begin
      sel   = (ID == off);
      wbyte = b_byte;
    end else if (len[1]) begin
      sel   = (ID[1] == off[1]);
      wbyte = b_half;
    end
  end
endmodule

module darkriscv_wb_dbridge #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_drd_i,
  input  logic        core_dwr_i,
  input  logic [31:0] core_daddr_i,
  input  logic [31:0] core_datao_i,
  input  logic [2:0]  core_dlen_i,
  output logic [31:0] core_datai_o,
  output logic        core_hlt_o,
  output logic        core_berr_o,
  output logic        data_mem_cyc_o,
  output logic        data_mem_stb_o,
  output logic        data_mem_we_o,
  output logic [3:0]  data_mem_sel_o,
  output logic [31:0] data_mem_addr_o,
  output logic [31:0] data_mem_data_o,
  input  logic [31:0] data_mem_data_i,
  input  logic        data_mem_ack_i,
  input  logic        data_mem_err_i
);
  localparam int NUM_LANES = 4;
  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  len;
  } req_t;

  state_t                        state;
  req_t                          rq;
  logic                          cyc, berr;
  logic [31:0]                   datai;
  logic [CNT_WIDTH-1:0]          cnt;
  logic                          req, legal, timeout;
  logic [NUM_LANES-1:0]          lane_sel;
  logic [NUM_LANES-1:0][7:0]     lane_wd;
  logic [31:0]                   rd_sh, rd_al;

  assign req     = core_drd_i | core_dwr_i;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LIM);

  // Stall in the request cycle itself and for the whole bus cycle.
  assign core_hlt_o = rst_n & (((state == IDLE) & req) | (state == BUS));

  assign core_datai_o    = datai;
  assign core_berr_o     = berr;
  assign data_mem_cyc_o  = cyc;
  assign data_mem_stb_o  = cyc;
  assign data_mem_we_o   = rq.we;
  assign data_mem_sel_o  = rq.sel;
  assign data_mem_addr_o = rq.addr;
  assign data_mem_data_o = rq.data;

  // Size/alignment legality; non-one-hot sizes are illegal.
  always_comb begin
    case (core_dlen_i)
      3'b001:  legal = 1'b1;
      3'b010:  legal = ~core_daddr_i[0];
      3'b100:  legal = (core_daddr_i[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    darkriscv_wb_dbridge_lane #(.LANE(i)) u_lane (
      .off    (core_daddr_i[1:0]),
      .len    (core_dlen_i),
      .b_byte (core_datao_i[7:0]),
      .b_half (core_datao_i[8*(i%2) +: 8]),
      .b_word (core_datao_i[8*i +: 8]),
      .sel    (lane_sel[i]),
      .wbyte  (lane_wd[i])
    );
  end

  // Right-align the addressed bytes and zero-extend to the access size.
  assign rd_sh = data_mem_data_i >> {rq.off, 3'b000};
  always_comb begin
    rd_al = rd_sh;
    if (rq.len[0])      rd_al = {24'h0, rd_sh[7:0]};
    else if (rq.len[1]) rd_al = {16'h0, rd_sh[15:0]};
  end

  // Request/bus/response FSM with registered bus and core outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rq    <= '0;
      cyc   <= 1'b0;
      berr  <= 1'b0;
      datai <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              rq.we   <= core_dwr_i;
              rq.sel  <= lane_sel;
              rq.addr <= {core_daddr_i[31:2], 2'b00};
              rq.data <= lane_wd;
              rq.off  <= core_daddr_i[1:0];
              rq.len  <= core_dlen_i;
              cyc     <= 1'b1;
              cnt     <= '0;
              state   <= BUS;
            end else begin
              // Misaligned/bad size: report without touching the bus.
              berr  <= 1'b1;
              state <= DONE;
            end
          end
        end
        BUS: begin
          if (data_mem_err_i || timeout) begin
            cyc   <= 1'b0;
            berr  <= 1'b1;
            datai <= '0;
            cnt   <= '0;
            state <= DONE;
          end else if (data_mem_ack_i) begin
            cyc   <= 1'b0;
            if (!rq.we) datai <= rd_al;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          // Strobes still high here belong to the access just served.
          berr  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/darkriscv_wb_dbridge.md
Name: darkriscv_wb_dbridge

Overview:
- Sequential bridge between the darkriscv native data port (DRD/DWR/DADDR/DATAO/DATAI/DLEN/HLT/BERR) and the Controller's second-memory Wishbone-classic port (data_mem_*).
- Sits directly downstream of the core and upstream of the Controller.
- Replaces the direct cyc/stb strapping with four functions:
  - a registered request;
  - byte-lane select generation;
  - a core stall (HLT) while the bus is busy;
  - read-data alignment and bus-error/timeout reporting.

Parameters:
- TIMEOUT_CYCLES, 1023: BUS-state cycles without ack/err before a timeout error is flagged. 0 disables the timeout.
- CNT_WIDTH, 16: width of the timeout counter. TIMEOUT_CYCLES must fit in it.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- core_drd_i  input  1  core read strobe
- core_dwr_i  input  1  core write strobe
- core_daddr_i  input  32  byte address
- core_datao_i  input  32  write data, right-aligned
- core_dlen_i  input  3  size, one-hot: 001 byte, 010 half, 100 word
- core_datai_o  output  32  read data, right-aligned, zero-extended
- core_hlt_o  output  1  stall request to core HLT
- core_berr_o  output  1  bus-error pulse to core BERR
- data_mem_cyc_o  output  1  Wishbone cycle
- data_mem_stb_o  output  1  Wishbone strobe
- data_mem_we_o  output  1  Wishbone write enable
- data_mem_sel_o  output  4  byte-lane select
- data_mem_addr_o  output  32  word address; bits [1:0] are always 0
- data_mem_data_o  output  32  write data, lane-replicated
- data_mem_data_i  input  32  read data
- data_mem_ack_i  input  1  Wishbone acknowledge
- data_mem_err_i  input  1  Wishbone error

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE;
  - all outputs 0, including cyc/stb/we/sel/addr/data_o, core_datai_o, core_berr_o;
  - the timeout counter clears.
  - A reset mid-cycle drops cyc/stb immediately. No ack is awaited afterwards.
- Request detection: req = core_drd_i | core_dwr_i, sampled only in IDLE.
  - If both strobes are high, the access is a write.
  - Strobes held high during DONE are ignored: that access has already been served.
- Alignment check, evaluated in IDLE on req:
  - Legal: byte at any address; half with addr[0]=0; word with addr[1:0]=0.
  - Illegal: any other combination, or a core_dlen_i that is not one-hot.
- core_hlt_o = (IDLE & req) | BUS. It is combinational, so the core stalls in the request cycle itself.
- State IDLE:
  - On a legal req: register addr&~3, we, sel, data_o; go to BUS.
  - On an illegal req: go to DONE with an error; no bus cycle is issued.
- State BUS:
  - cyc=stb=1 from registers; the counter increments each cycle.
  - ack: latch aligned read data (reads only); go to DONE, berr=0.
  - err, or counter reaching TIMEOUT_CYCLES-1 (when TIMEOUT_CYCLES≠0): go to DONE, berr=1, datai=0.
  - If ack and err arrive together, err wins.
- State DONE, one cycle:
  - cyc=stb=0, hlt=0;
  - core_datai_o holds the latched value; core_berr_o holds the registered error flag;
  - next state is IDLE; berr clears on leaving DONE.
  - core_datai_o keeps its last value until the next read completes.
- Lane select (off = addr[1:0]):
  - byte: 0001<<off;
  - half: 0011<<off;
  - word: 1111.
- Write data:
  - byte: {4{d[7:0]}};
  - half: {2{d[15:0]}};
  - word: d.
- Read data: (data_mem_data_i >> 8*off), masked to 8/16/32 bits and zero-extended. Sign extension is the core's responsibility.
- Latency with a zero-wait slave: request cycle T0 (hlt=1), T1 BUS with ack, T2 DONE (data valid, hlt=0). The core sees a 2-cycle stall, plus N cycles for N slave wait states.
- Back-to-back accesses: the earliest next request is sampled in the cycle after DONE. There is no pipelining, so at most one outstanding transaction.
- Bus registers stay constant through BUS, as Wishbone-classic requires.

Test Plan:
- Word read at 0x0000_1000, slave acks in 1st BUS cycle with 0xDEADBEEF -> cyc/stb high exactly 1 cycle, sel=1111, addr=0x1000, core_datai_o=0xDEADBEEF in DONE, hlt high exactly 2 cycles.
- Byte write 0xA5 to 0x0000_2003 -> sel=1000, data_o=0xA5A5A5A5, we=1, addr=0x2000. Half read at 0x2002 with bus 0x1234_5678 -> sel=1100, datai=0x0000_1234.
- Slave inserts 3 wait states before ack -> cyc/stb high 4 cycles with stable addr/sel/data, hlt high 5 cycles, berr=0.
- Misaligned word read at 0x0000_3002 -> no cyc ever asserted, berr=1 for one cycle, hlt high 1 cycle. dlen=3'b011 -> same error response.
- Two error cases:
  - TIMEOUT_CYCLES=8, no ack -> BUS ends after 8 cycles, berr=1, datai=0.
  - data_mem_err_i asserted together with ack -> berr=1.
- rst_n pulled low during BUS -> cyc/stb/hlt drop asynchronously. After release, a fresh read completes normally with no stale berr/data.
